// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares one SDRAM master port among three audio clients: play (0),
// record (1) and PitchCore (2). Fixed priority play > record > pitch, with a
// starvation guard that forces pitch through after STARVE_LIMIT consecutive
// play/record grants made while pitch was waiting. One transaction is in
// flight at a time.
//
// Ports
//   i_clk, i_rst      : clock, asynchronous active-low reset
//   cl_read/cl_write  : per-client request bits (bit k = client k)
//   cl_addr           : per-client word address
//   cl_writedata      : per-client write data
//   cl_readdata       : read data broadcast, valid with cl_finished[k]
//   cl_finished       : per-client one-cycle completion pulse
//   sdram_read/write  : command to SDRAM controller wrapper
//   sdram_addr        : address to SDRAM controller
//   sdram_writedata   : write data to SDRAM controller
//   sdram_readdata    : read data from SDRAM controller
//   sdram_finished    : one-cycle pulse, write done or read data valid
//   grant             : client owning the port, 2'd3 = none
//   busy              : high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        cl_read,
  input  logic [2:0]        cl_write,
  input  logic [ADDR_W-1:0] cl_addr      [2:0],
  input  logic [DATA_W-1:0] cl_writedata [2:0],
  output logic [DATA_W-1:0] cl_readdata,
  output logic [2:0]        cl_finished,
  output logic              sdram_read,
  output logic              sdram_write,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_writedata,
  input  logic [DATA_W-1:0] sdram_readdata,
  input  logic              sdram_finished,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);
  localparam logic [1:0] LP_NONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_grant;
  logic [7:0]          r_starve_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_write;
  logic [DATA_W-1:0]   r_readdata;

  logic [2:0]          w_pending;
  logic                w_any;
  logic [1:0]          w_win;

  assign w_pending = cl_read | cl_write;
  assign w_any     = |w_pending;

  // Pitch is forced through once it has been passed over STARVE_LIMIT times;
  // otherwise the lowest pending index wins.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_win = 2'd0;
    if (w_pending[2] && (r_starve_cnt == LP_LIMIT)) w_win = 2'd2;
    else if (w_pending[0])                          w_win = 2'd0;
    else if (w_pending[1])                          w_win = 2'd1;
    else if (w_pending[2])                          w_win = 2'd2;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic. sdram_finished is only meaningful in ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: if (sdram_finished) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, latched transaction copy, read data and starvation counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_grant      <= LP_NONE;
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_is_write   <= 1'b0;
      r_readdata   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant    <= w_win;
            r_addr     <= cl_addr[w_win];
            r_wdata    <= cl_writedata[w_win];
            // read+write together is treated as a write
            r_is_write <= cl_write[w_win];
            if (w_win == 2'd2)
              r_starve_cnt <= '0;
            else if (w_pending[2])
              r_starve_cnt <= (r_starve_cnt == LP_LIMIT) ? r_starve_cnt
                                                         : r_starve_cnt + 8'd1;
            else
              r_starve_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (sdram_finished && !r_is_write) r_readdata <= sdram_readdata;
        end
        S_RESP: begin
          r_grant <= LP_NONE;
        end
        default: ;
      endcase
    end
  end

  // Commands come from the latched copy so client inputs may move mid-access.
  assign sdram_read      = (r_state == S_ISSUE) && !r_is_write;
  assign sdram_write     = (r_state == S_ISSUE) &&  r_is_write;
  assign sdram_addr      = r_addr;
  assign sdram_writedata = r_wdata;
  assign cl_readdata     = r_readdata;
  assign cl_finished     = (r_state == S_RESP) ? (3'b001 << r_grant) : 3'b000;
  assign grant           = r_grant;
  assign busy            = (r_state != S_IDLE);

endmodule
